// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART byte receiver
// Purpose: FSM state encoding, data width and default timing for uart_rx_byte.
// Ports: none (package).
package uart_pkg;

  localparam int DATA_BITS        = 8;
  localparam int CLKS_PER_BIT_DEF = 5208;  // 50 MHz / 9600 baud
  localparam int CNT_W_DEF        = 13;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

endpackage

// File: rtl/uart_rx_byte_if.sv
// rtl/uart_rx_byte_if.sv - serial line in, received byte and status out
// Purpose: bundles the serial input and the receiver outputs.
// Ports (signals):
//   rx        serial line, idle high
//   rx_data   last correctly framed byte, held between frames
//   rx_valid  one-cycle pulse, rx_data updated this cycle
//   frame_err one-cycle pulse, stop bit sampled low
//   busy      receiver not idle
// Modports: master = receiver, slave = line driver / byte consumer.
interface uart_rx_byte_if;
  import uart_pkg::*;

  logic                 rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 busy;

  modport master (
    input  rx,
    output rx_data,
    output rx_valid,
    output frame_err,
    output busy
  );

  modport slave (
    output rx,
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  busy
  );

endinterface

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchroniser with falling-edge detect
// Purpose: brings the asynchronous rx line into the clk domain and flags
//          a high-to-low transition as a candidate start bit.
// Ports:
//   clk          in  system clock
//   rst          in  asynchronous active-high reset
//   i_rx         in  raw serial line
//   o_rx_s       out synchronised line
//   o_start_edge out rx_s_d high and rx_s low (falling edge)
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_rx,
  output logic o_rx_s,
  output logic o_start_edge
);

  logic r_meta;
  logic r_rx_s;
  logic r_rx_s_d;

  // All flops reset high so that leaving reset never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta   <= 1'b1;
      r_rx_s   <= 1'b1;
      r_rx_s_d <= 1'b1;
    end else begin
      r_meta   <= i_rx;
      r_rx_s   <= r_meta;
      r_rx_s_d <= r_rx_s;
    end
  end

  // Only a transition qualifies, so a line held low cannot retrigger.
  assign o_rx_s       = r_rx_s;
  assign o_start_edge = r_rx_s_d & ~r_rx_s;

endmodule

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 UART receiver, LSB first, holds last good byte
// Purpose: recovers bytes from the serial line; rx_data feeds UART_OUT.
// Ports:
//   clk  in  system clock, rising edge
//   rst  in  asynchronous active-high reset
//   bus  uart_rx_byte_if.master: rx in; rx_data, rx_valid, frame_err, busy out
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_byte_if.master bus
);

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] LP_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [2:0]       LP_MSB  = 3'(DATA_BITS - 1);

  logic w_rx_s;
  logic w_start_edge;

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [2:0]           r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_frame_err;
  logic                 r_busy;

  uart_rx_sync u_sync (
    .clk          (clk),
    .rst          (rst),
    .i_rx         (bus.rx),
    .o_rx_s       (w_rx_s),
    .o_start_edge (w_start_edge)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start_edge) begin
            r_state <= ST_START;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_START: begin
          // Re-check the line half a bit in; a high line means a glitch.
          if (r_cnt == LP_HALF) begin
            r_cnt <= '0;
            if (!w_rx_s) begin
              r_state   <= ST_DATA;
              r_bit_idx <= '0;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_DATA: begin
          // Aligned to mid start bit, so every full-bit step lands mid-bit.
          if (r_cnt == LP_LAST) begin
            r_cnt              <= '0;
            r_shift[r_bit_idx] <= w_rx_s;
            if (r_bit_idx == LP_MSB) begin
              r_state <= ST_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_STOP: begin
          // Leaving at mid stop bit gives the next start edge half a bit of slack.
          if (r_cnt == LP_LAST) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            if (w_rx_s) begin
              r_rx_data  <= r_shift;
              r_rx_valid <= 1'b1;
            end else begin
              r_frame_err <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rx_data   = r_rx_data;
  assign bus.rx_valid  = r_rx_valid;
  assign bus.frame_err = r_frame_err;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_uart_rx_byte.sv
// tb/tb_uart_rx_byte.sv - self-checking bench for uart_rx_byte
`timescale 1ns/1ps
module tb_uart_rx_byte;

  localparam int  CPB    = 16;
  localparam real CLK_NS = 10.0;
  localparam real BIT_NS = CPB * CLK_NS;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_rx_byte_if u_if ();

  uart_rx_byte #(
    .CLKS_PER_BIT (CPB),
    .CNT_W        (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int valid_cnt = 0;
  int err_cnt   = 0;
  int ovl_cnt   = 0;
  int busy_run  = 0;
  int busy_max  = 0;
  logic [7:0] exp_q[$];
  int         valid_times[$];

  always @(posedge clk) cyc++;

  // Scoreboard side: every rx_valid pops the oldest expected byte.
  always @(negedge clk) begin
    if (!rst) begin
      if (u_if.rx_valid) begin
        logic [7:0] exp_b;
        valid_cnt++;
        valid_times.push_back(cyc);
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: got rx_data=%02h, expected no byte", u_if.rx_data);
        end else begin
          exp_b = exp_q.pop_front();
          if (u_if.rx_data !== exp_b) begin
            n_fail++;
            $display("FAIL sb_data: got %02h, expected %02h", u_if.rx_data, exp_b);
          end
        end
      end
      if (u_if.frame_err) err_cnt++;
      if (u_if.rx_valid && u_if.frame_err) ovl_cnt++;
      if (u_if.busy) busy_run++;
      else busy_run = 0;
      if (busy_run > busy_max) busy_max = busy_run;
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic stop_bit, input real bit_ns);
    u_if.rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      u_if.rx = d[i];
      #(bit_ns);
    end
    u_if.rx = stop_bit;
    #(bit_ns);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    u_if.rx = 1'b1;
    rst = 1'b1;
    wait_cycles(4);
    n_checks++; if (u_if.rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %02h, expected 00", u_if.rx_data); end
    n_checks++; if (u_if.rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, expected 0", u_if.rx_valid); end
    n_checks++; if (u_if.frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b, expected 0", u_if.frame_err); end
    n_checks++; if (u_if.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", u_if.busy); end
    @(posedge clk); #2;
    rst = 1'b0;
    wait_cycles(5);
  endtask

  task automatic test_single;
    int v0 = valid_cnt;
    int e0 = err_cnt;
    exp_q.push_back(8'h05);
    send_byte(8'h05, 1'b1, BIT_NS);
    wait_cycles(20);
    n_checks++; if (valid_cnt - v0 != 1) begin n_fail++; $display("FAIL single_pulses: got %0d, expected 1", valid_cnt - v0); end
    n_checks++; if (err_cnt != e0) begin n_fail++; $display("FAIL single_ferr: got %0d, expected %0d", err_cnt, e0); end
    n_checks++; if (u_if.rx_data !== 8'h05) begin n_fail++; $display("FAIL single_data: got %02h, expected 05", u_if.rx_data); end
  endtask

  task automatic test_back_to_back;
    int v0 = valid_cnt;
    int dt;
    valid_times.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    send_byte(8'hA5, 1'b1, BIT_NS);
    send_byte(8'h3C, 1'b1, BIT_NS);
    wait_cycles(20);
    n_checks++; if (valid_cnt - v0 != 2) begin n_fail++; $display("FAIL b2b_pulses: got %0d, expected 2", valid_cnt - v0); end
    dt = (valid_times.size() >= 2) ? valid_times[1] - valid_times[0] : -1;
    n_checks++; if (dt < 155 || dt > 165) begin n_fail++; $display("FAIL b2b_spacing: got %0d cycles, expected 155..165", dt); end
    n_checks++; if (u_if.rx_data !== 8'h3C) begin n_fail++; $display("FAIL b2b_data: got %02h, expected 3C", u_if.rx_data); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_queue: got %0d left, expected 0", exp_q.size()); end
  endtask

  task automatic test_glitch;
    int v0 = valid_cnt;
    int e0 = err_cnt;
    busy_max = 0;
    u_if.rx = 1'b0;
    #(4 * CLK_NS);
    u_if.rx = 1'b1;
    wait_cycles(40);
    n_checks++; if (busy_max < 1 || busy_max > 8) begin n_fail++; $display("FAIL glitch_busy_len: got %0d, expected 1..8", busy_max); end
    n_checks++; if (u_if.busy !== 1'b0) begin n_fail++; $display("FAIL glitch_idle: got busy=%b, expected 0", u_if.busy); end
    n_checks++; if (valid_cnt != v0 || err_cnt != e0) begin n_fail++; $display("FAIL glitch_pulses: got valid+%0d err+%0d, expected 0 0", valid_cnt - v0, err_cnt - e0); end
  endtask

  task automatic test_frame_err;
    int v0 = valid_cnt;
    int e0 = err_cnt;
    send_byte(8'h08, 1'b0, BIT_NS);
    // Line stays low for well over a frame; no new frame may start.
    wait_cycles(300);
    n_checks++; if (err_cnt - e0 != 1) begin n_fail++; $display("FAIL ferr_pulses: got %0d, expected 1", err_cnt - e0); end
    n_checks++; if (valid_cnt != v0) begin n_fail++; $display("FAIL ferr_valid: got %0d, expected 0", valid_cnt - v0); end
    n_checks++; if (u_if.rx_data !== 8'h3C) begin n_fail++; $display("FAIL ferr_data: got %02h, expected 3C", u_if.rx_data); end
    n_checks++; if (u_if.busy !== 1'b0) begin n_fail++; $display("FAIL ferr_retrigger: got busy=%b, expected 0", u_if.busy); end
    u_if.rx = 1'b1;
    wait_cycles(20);
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] d = 8'hF6;
    int v0;
    u_if.rx = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) begin
      u_if.rx = d[i];
      #(BIT_NS);
    end
    u_if.rx = d[4];
    #(BIT_NS / 2 + 3.0);
    rst = 1'b1;
    #1;
    n_checks++; if (u_if.rx_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_data: got %02h, expected 00", u_if.rx_data); end
    n_checks++; if (u_if.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b, expected 0", u_if.busy); end
    n_checks++; if (u_if.rx_valid !== 1'b0 || u_if.frame_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_pulses: got valid=%b ferr=%b, expected 0 0", u_if.rx_valid, u_if.frame_err); end
    u_if.rx = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    wait_cycles(5);
    v0 = valid_cnt;
    exp_q.push_back(8'h01);
    send_byte(8'h01, 1'b1, BIT_NS);
    wait_cycles(20);
    n_checks++; if (valid_cnt - v0 != 1) begin n_fail++; $display("FAIL rstmid_recover_pulses: got %0d, expected 1", valid_cnt - v0); end
    n_checks++; if (u_if.rx_data !== 8'h01) begin n_fail++; $display("FAIL rstmid_recover_data: got %02h, expected 01", u_if.rx_data); end
  endtask

  task automatic test_random_baud;
    int v0 = valid_cnt;
    int e0 = err_cnt;
    for (int k = 0; k < 20; k++) begin
      logic [7:0] b;
      real        scale;
      b = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 2))
        0:       scale = 0.98;
        1:       scale = 1.02;
        default: scale = 1.00;
      endcase
      exp_q.push_back(b);
      send_byte(b, 1'b1, BIT_NS * scale);
    end
    wait_cycles(40);
    n_checks++; if (valid_cnt - v0 != 20) begin n_fail++; $display("FAIL rand_pulses: got %0d, expected 20", valid_cnt - v0); end
    n_checks++; if (err_cnt != e0) begin n_fail++; $display("FAIL rand_ferr: got %0d, expected 0", err_cnt - e0); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_queue: got %0d left, expected 0", exp_q.size()); end
    n_checks++; if (ovl_cnt != 0) begin n_fail++; $display("FAIL pulse_overlap: got %0d, expected 0", ovl_cnt); end
  endtask

  initial begin
    u_if.rx = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid_frame();
    test_random_baud();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
